// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolution and an iterative
// 33-cycle multiply/divide unit with HI/LO registers.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Flush_EX,
  input  logic [3:0]  ALUControl_EX,
  input  logic        ALUSrc_EX,
  input  logic        RegDst_EX,
  input  logic [1:0]  ALUOF_EX,
  input  logic        Branch_EX,
  input  logic [2:0]  BranchSt_EX,
  input  logic [31:0] PCPlus4_EX,
  input  logic [31:0] ReadRs_EX,
  input  logic [31:0] ReadRt_EX,
  input  logic [31:0] Signimm_EX,
  input  logic [4:0]  RT_EX,
  input  logic [4:0]  RD_EX,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] ALUOut_MEM,
  input  logic [31:0] Result_WB,
  output logic [31:0] ALUOut_EX,
  output logic [31:0] WriteData_EX,
  output logic [4:0]  WriteReg_EX,
  output logic        Overflow_EX,
  output logic        BranchTaken_EX,
  output logic [31:0] BranchTarget_EX,
  output logic        Stall_EX
);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_XOR  = 4'b0011, OP_SUB  = 4'b0110, OP_SLT  = 4'b0111,
                         OP_NOR  = 4'b1100, OP_MFHI = 4'b1101, OP_MFLO = 4'b1110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  md_state_t          state;
  logic [4:0]         cnt;
  logic [31:0]        hi_q, lo_q;
  logic [63:0]        acc_q;
  logic [31:0]        opb_q, dividend_q;
  logic               is_div_q, neg_res_q, neg_rem_q, div0_q;

  logic [31:0]        src_a, fwd_b, src_b, sum, diff;
  logic signed [31:0] a_s, b_s;
  logic               md_op, start, md_signed;
  logic [32:0]        mul_upper, div_shift, div_rem;
  logic               div_ge;
  logic [63:0]        step_next, prod;
  logic [31:0]        fin_hi, fin_lo;
  logic               unused_bits;

  // Conditional two's-complement negate used for sign/magnitude conversion.
  function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] v);
    return neg ? (64'd0 - v) : v;
  endfunction

  assign unused_bits = ALUOF_EX[1] ^ div_rem[32];

  // Forwarding muxes for both register operands, then the immediate select.
  always_comb begin
    case (ForwardA)
      2'b01:   src_a = Result_WB;
      2'b10:   src_a = ALUOut_MEM;
      default: src_a = ReadRs_EX;
    endcase
    case (ForwardB)
      2'b01:   fwd_b = Result_WB;
      2'b10:   fwd_b = ALUOut_MEM;
      default: fwd_b = ReadRt_EX;
    endcase
    src_b = ALUSrc_EX ? Signimm_EX : fwd_b;
  end

  assign WriteData_EX    = fwd_b;
  assign WriteReg_EX     = RegDst_EX ? RD_EX : RT_EX;
  assign BranchTarget_EX = PCPlus4_EX + {Signimm_EX[29:0], 2'b00};
  assign sum             = src_a + src_b;
  assign diff            = src_a - src_b;
  assign a_s             = src_a;
  assign b_s             = src_b;

  // ALU result select; HI/LO reads see the registered value.
  always_comb begin
    case (ALUControl_EX)
      OP_AND:  ALUOut_EX = src_a & src_b;
      OP_OR:   ALUOut_EX = src_a | src_b;
      OP_ADD:  ALUOut_EX = sum;
      OP_XOR:  ALUOut_EX = src_a ^ src_b;
      OP_SUB:  ALUOut_EX = diff;
      OP_SLT:  ALUOut_EX = {31'd0, a_s < b_s};
      OP_NOR:  ALUOut_EX = ~(src_a | src_b);
      OP_MFHI: ALUOut_EX = hi_q;
      OP_MFLO: ALUOut_EX = lo_q;
      default: ALUOut_EX = 32'd0;
    endcase
  end

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
  assign Overflow_EX = ALUOF_EX[0] &
    (((ALUControl_EX == OP_ADD) & ~(src_a[31] ^ src_b[31]) & (sum[31] ^ src_a[31])) |
     ((ALUControl_EX == OP_SUB) &  (src_a[31] ^ src_b[31]) & (diff[31] ^ src_a[31])));

  // Branch condition always compares against forwarded Rt, never the immediate.
  always_comb begin
    case (BranchSt_EX)
      3'b000:  BranchTaken_EX = Branch_EX & (src_a == fwd_b);
      3'b001:  BranchTaken_EX = Branch_EX & (src_a != fwd_b);
      3'b010:  BranchTaken_EX = Branch_EX & (a_s <= 0);
      3'b011:  BranchTaken_EX = Branch_EX & (a_s > 0);
      3'b100:  BranchTaken_EX = Branch_EX & (a_s < 0);
      3'b101:  BranchTaken_EX = Branch_EX & (a_s >= 0);
      default: BranchTaken_EX = 1'b0;
    endcase
  end

  assign md_op     = (ALUControl_EX[3:2] == 2'b10);
  assign md_signed = ~ALUControl_EX[0];
  assign start     = (state == IDLE) & md_op & ~Flush_EX;
  assign Stall_EX  = start | (state == RUN);

  // One iteration: shift-add multiply on {upper, multiplier} or a restoring divide step on {rem, quo}.
  always_comb begin
    mul_upper = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
    step_next = is_div_q ? {div_rem[31:0], acc_q[30:0], div_ge}
                         : {mul_upper, acc_q[31:1]};
    prod      = cneg64(neg_res_q, step_next);
    if (!is_div_q) begin
      fin_hi = prod[63:32];
      fin_lo = prod[31:0];
    end else if (div0_q) begin
      fin_hi = dividend_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = cneg32(neg_rem_q, step_next[63:32]);
      fin_lo = cneg32(neg_res_q, step_next[31:0]);
    end
  end

  // Control FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          cnt   <= 5'd0;
        end
        RUN: if (Flush_EX) begin
          state <= IDLE;
        end else begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture as magnitudes (B is forwarded Rt) and the per-cycle working register.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q      <= {32'd0, cneg32(md_signed & src_a[31], src_a)};
      opb_q      <= cneg32(md_signed & fwd_b[31], fwd_b);
      dividend_q <= src_a;
      is_div_q   <= ALUControl_EX[1];
      neg_res_q  <= md_signed & (src_a[31] ^ fwd_b[31]);
      neg_rem_q  <= md_signed & src_a[31];
      div0_q     <= (fwd_b == 32'd0);
    end else if (state == RUN) begin
      acc_q <= step_next;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU, forwarding, branch and multiply/divide.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, Flush_EX, ALUSrc_EX, RegDst_EX, Branch_EX;
  logic [3:0]  ALUControl_EX;
  logic [1:0]  ALUOF_EX, ForwardA, ForwardB;
  logic [2:0]  BranchSt_EX;
  logic [31:0] PCPlus4_EX, ReadRs_EX, ReadRt_EX, Signimm_EX, ALUOut_MEM, Result_WB;
  logic [4:0]  RT_EX, RD_EX;
  logic [31:0] ALUOut_EX, WriteData_EX, BranchTarget_EX;
  logic [4:0]  WriteReg_EX;
  logic        Overflow_EX, BranchTaken_EX, Stall_EX;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_model = 32'd0;
  logic [31:0] lo_model = 32'd0;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, XOR_ = 4'b0011,
                         SUB_ = 4'b0110, SLT_ = 4'b0111, NOR_ = 4'b1100, MULT_ = 4'b1000,
                         MULTU_ = 4'b1001, DIV_ = 4'b1010, DIVU_ = 4'b1011,
                         MFHI_ = 4'b1101, MFLO_ = 4'b1110;

  ex_stage dut (
    .clk(clk), .rst(rst), .Flush_EX(Flush_EX), .ALUControl_EX(ALUControl_EX),
    .ALUSrc_EX(ALUSrc_EX), .RegDst_EX(RegDst_EX), .ALUOF_EX(ALUOF_EX),
    .Branch_EX(Branch_EX), .BranchSt_EX(BranchSt_EX), .PCPlus4_EX(PCPlus4_EX),
    .ReadRs_EX(ReadRs_EX), .ReadRt_EX(ReadRt_EX), .Signimm_EX(Signimm_EX),
    .RT_EX(RT_EX), .RD_EX(RD_EX), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .ALUOut_MEM(ALUOut_MEM), .Result_WB(Result_WB), .ALUOut_EX(ALUOut_EX),
    .WriteData_EX(WriteData_EX), .WriteReg_EX(WriteReg_EX), .Overflow_EX(Overflow_EX),
    .BranchTaken_EX(BranchTaken_EX), .BranchTarget_EX(BranchTarget_EX), .Stall_EX(Stall_EX)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Register-operand ALU op, no forwarding; leaves outputs settled for checking.
  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl_EX = op; ReadRs_EX = a; ReadRt_EX = b;
    ForwardA = 2'b00; ForwardB = 2'b00; ALUSrc_EX = 1'b0;
    #1;
  endtask

  // Runs one multiply/divide, counts stall cycles, checks old-value read on the
  // final RUN cycle and the new HI/LO in DONE.
  task automatic md_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    ALUControl_EX = op; ReadRs_EX = a; ReadRt_EX = b;
    ForwardA = 2'b00; ForwardB = 2'b00; ALUSrc_EX = 1'b0;
    n = 0;
    #1;
    while (Stall_EX && n < 40) begin
      n++;
      if (n == 33) begin
        ALUControl_EX = MFLO_;
        #1;
        check_eq({tag, "_lo_old"}, ALUOut_EX, lo_model);
      end
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_stall_cycles"}, n, 33);
    ALUControl_EX = MFLO_; #1;
    check_eq({tag, "_lo"}, ALUOut_EX, exp_lo);
    ALUControl_EX = MFHI_; #1;
    check_eq({tag, "_hi"}, ALUOut_EX, exp_hi);
    lo_model = exp_lo;
    hi_model = exp_hi;
    @(negedge clk); #1;
    check_eq({tag, "_idle_stall"}, Stall_EX, 0);
  endtask

  // Starts a MULT, aborts at RUN cycle 10 via rst or flush, checks stall and HI/LO.
  task automatic md_abort(input logic use_rst);
    @(negedge clk);
    ALUControl_EX = MULT_; ReadRs_EX = 32'd12; ReadRt_EX = 32'd12;
    for (int i = 0; i < 11; i++) @(negedge clk);
    #1;
    check_eq(use_rst ? "rst_pre_stall" : "flush_pre_stall", Stall_EX, 1);
    if (use_rst) rst = 1'b1; else Flush_EX = 1'b1;
    ALUControl_EX = ADD_;
    @(negedge clk);
    rst = 1'b0; Flush_EX = 1'b0;
    #1;
    check_eq(use_rst ? "rst_stall" : "flush_stall", Stall_EX, 0);
    if (use_rst) begin
      hi_model = 32'd0;
      lo_model = 32'd0;
    end
    ALUControl_EX = MFLO_; #1;
    check_eq(use_rst ? "rst_lo" : "flush_lo", ALUOut_EX, lo_model);
    ALUControl_EX = MFHI_; #1;
    check_eq(use_rst ? "rst_hi" : "flush_hi", ALUOut_EX, hi_model);
  endtask

  initial begin
    rst = 1'b1; Flush_EX = 1'b0; ALUSrc_EX = 1'b0; RegDst_EX = 1'b0; Branch_EX = 1'b0;
    ALUControl_EX = ADD_; ALUOF_EX = 2'b00; ForwardA = 2'b00; ForwardB = 2'b00;
    BranchSt_EX = 3'b000; PCPlus4_EX = 32'd0; ReadRs_EX = 32'd0; ReadRt_EX = 32'd0;
    Signimm_EX = 32'd0; ALUOut_MEM = 32'd0; Result_WB = 32'd0; RT_EX = 5'd0; RD_EX = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_stall", Stall_EX, 0);
    ALUControl_EX = MFHI_; #1; check_eq("reset_hi", ALUOut_EX, 0);
    ALUControl_EX = MFLO_; #1; check_eq("reset_lo", ALUOut_EX, 0);

    // Logic / arithmetic operations
    alu(AND_, 32'hF0F0_00FF, 32'h0FF0_0F0F); check_eq("and", ALUOut_EX, 32'h00F0_000F);
    alu(OR_,  32'hF0F0_00FF, 32'h0FF0_0F0F); check_eq("or",  ALUOut_EX, 32'hFFF0_0FFF);
    alu(XOR_, 32'hF0F0_00FF, 32'h0FF0_0F0F); check_eq("xor", ALUOut_EX, 32'hFF00_0FF0);
    alu(NOR_, 32'hF0F0_00FF, 32'h0FF0_0F0F); check_eq("nor", ALUOut_EX, 32'h000F_F000);
    alu(SUB_, 32'd5, 32'd7);                 check_eq("sub", ALUOut_EX, 32'hFFFF_FFFE);
    alu(SLT_, 32'hFFFF_FFFF, 32'd1);         check_eq("slt_neg", ALUOut_EX, 32'd1);
    alu(SLT_, 32'd1, 32'hFFFF_FFFF);         check_eq("slt_pos", ALUOut_EX, 32'd0);
    alu(4'b0100, 32'h1234, 32'h5678);        check_eq("undef_op", ALUOut_EX, 32'd0);

    // Forwarding and immediate operand
    ALUControl_EX = ADD_; ALUSrc_EX = 1'b1; Signimm_EX = 32'd1; ReadRs_EX = 32'd9;
    ForwardA = 2'b10; ALUOut_MEM = 32'd5; #1;
    check_eq("fwd_mem_imm", ALUOut_EX, 32'd6);
    ALUSrc_EX = 1'b0; ForwardA = 2'b11; ReadRs_EX = 32'd1; ReadRt_EX = 32'd2;
    ForwardB = 2'b01; Result_WB = 32'h20; #1;
    check_eq("fwd_wb", ALUOut_EX, 32'h21);
    check_eq("writedata_fwd", WriteData_EX, 32'h20);
    ForwardB = 2'b11; #1;
    check_eq("fwd_reg11", ALUOut_EX, 32'd3);

    // Overflow detection
    alu(ADD_, 32'h7FFF_FFFF, 32'd1); ALUOF_EX = 2'b01; #1;
    check_eq("add_ovf_res", ALUOut_EX, 32'h8000_0000);
    check_eq("add_ovf_on", Overflow_EX, 1);
    ALUOF_EX = 2'b00; #1; check_eq("add_ovf_dis", Overflow_EX, 0);
    ALUOF_EX = 2'b10; #1; check_eq("add_ovf_bit1", Overflow_EX, 0);
    ALUOF_EX = 2'b01;
    alu(SUB_, 32'h8000_0000, 32'd1);
    check_eq("sub_ovf_res", ALUOut_EX, 32'h7FFF_FFFF);
    check_eq("sub_ovf_on", Overflow_EX, 1);
    alu(AND_, 32'h7FFF_FFFF, 32'd1); check_eq("and_no_ovf", Overflow_EX, 0);
    ALUOF_EX = 2'b00;

    // Destination register select
    RT_EX = 5'd3; RD_EX = 5'd7;
    RegDst_EX = 1'b1; #1; check_eq("wreg_rd", WriteReg_EX, 5'd7);
    RegDst_EX = 1'b0; #1; check_eq("wreg_rt", WriteReg_EX, 5'd3);

    // Branches
    Branch_EX = 1'b1; BranchSt_EX = 3'b001;
    alu(ADD_, 32'd3, 32'd3); check_eq("bne_eq", BranchTaken_EX, 0);
    alu(ADD_, 32'd3, 32'd4); check_eq("bne_ne", BranchTaken_EX, 1);
    BranchSt_EX = 3'b000; alu(ADD_, 32'd3, 32'd3);
    ALUSrc_EX = 1'b1; Signimm_EX = 32'd9; #1;
    check_eq("beq_uses_rt", BranchTaken_EX, 1);
    ALUSrc_EX = 1'b0;
    BranchSt_EX = 3'b010; alu(ADD_, 32'd0, 32'd5);           check_eq("blez_zero", BranchTaken_EX, 1);
    BranchSt_EX = 3'b011; #1;                                 check_eq("bgtz_zero", BranchTaken_EX, 0);
    BranchSt_EX = 3'b100; alu(ADD_, 32'hFFFF_FFFF, 32'd0);   check_eq("bltz_neg", BranchTaken_EX, 1);
    BranchSt_EX = 3'b101; #1;                                 check_eq("bgez_neg", BranchTaken_EX, 0);
    BranchSt_EX = 3'b110; alu(ADD_, 32'd0, 32'd0);           check_eq("bst110", BranchTaken_EX, 0);
    BranchSt_EX = 3'b000; Branch_EX = 1'b0; #1;              check_eq("no_branch", BranchTaken_EX, 0);
    PCPlus4_EX = 32'h100; Signimm_EX = 32'hFFFF_FFFF; #1;
    check_eq("btarget", BranchTarget_EX, 32'h0000_00FC);

    // Multiply / divide
    md_run("mult",  MULT_,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_run("multu", MULTU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    md_run("div",   DIV_,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu0", DIVU_,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    md_run("div0n", DIV_,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    md_run("divmin", DIV_,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    md_run("divu",  DIVU_,  32'd100,       32'd7,         32'd2,         32'd14);

    // Flush and reset during RUN
    md_abort(1'b0);
    md_abort(1'b1);

    // Flush in IDLE blocks the start
    @(negedge clk);
    ALUControl_EX = MULT_; ReadRs_EX = 32'd3; ReadRt_EX = 32'd3; Flush_EX = 1'b1; #1;
    check_eq("idle_flush_stall", Stall_EX, 0);
    @(negedge clk);
    Flush_EX = 1'b0; ALUControl_EX = MFLO_; #1;
    check_eq("idle_flush_nostart", Stall_EX, 0);
    check_eq("idle_flush_lo", ALUOut_EX, lo_model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "timeout");
  end

endmodule
